// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - fetch/decode/writeback sequencer driving cpu_top register file and ALU
// Holds PC and carry flag; instruction and immediate words arrive over a req/ack fetch handshake.
module cpu_ctrl_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int PC_WIDTH   = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [ADDR_WIDTH-1:0] reg_read_addr1,
   output logic [ADDR_WIDTH-1:0] reg_read_addr2,
   output logic [3:0]            alu_sel,
   output logic                  alu_mode,
   output logic                  alu_cin,
   output logic [DATA_WIDTH-1:0] alu_b_imm,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_cout,
   output logic                  reg_write_enable,
   output logic [ADDR_WIDTH-1:0] reg_write_addr,
   output logic [DATA_WIDTH-1:0] reg_write_data,
   output logic                  busy,
   output logic                  halted,
   output logic                  carry_flag
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_DECODE    = 3'd2;
   localparam logic [2:0] S_FETCH_IMM = 3'd3;
   localparam logic [2:0] S_EXEC      = 3'd4;
   localparam logic [2:0] S_WB        = 3'd5;
   localparam logic [2:0] S_HALTED    = 3'd6;

   localparam logic [1:0] T_ALU_RR = 2'b00;
   localparam logic [1:0] T_ALU_RI = 2'b01;
   localparam logic [1:0] T_LDI    = 2'b10;

   localparam logic [3:0] OP_HALT = 4'b0001;
   localparam logic [3:0] OP_JMP  = 4'b0010;
   localparam logic [3:0] OP_JC   = 4'b0011;

   logic [2:0]            r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic                  r_carry;
   logic [15:2]           r_instr;
   logic [DATA_WIDTH-1:0] r_imm;

   logic [1:0]            r_type;
   logic [3:0]            r_sel;
   logic                  r_mode;
   logic                  r_cin;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic [ADDR_WIDTH-1:0] r_rs;

   logic [ADDR_WIDTH-1:0] r_read_addr1;
   logic [ADDR_WIDTH-1:0] r_read_addr2;
   logic [3:0]            r_alu_sel;
   logic                  r_alu_mode;
   logic                  r_alu_cin;
   logic [DATA_WIDTH-1:0] r_alu_b_imm;

   logic [1:0]            w_type;
   logic [3:0]            w_sel;
   logic                  w_mode;
   logic                  w_cin;
   logic [ADDR_WIDTH-1:0] w_rd;
   logic [ADDR_WIDTH-1:0] w_rs;
   logic                  w_fetching;
   logic                  w_ack;
   logic                  w_in_wb;
   logic                  w_take_jump;
   logic [PC_WIDTH-1:0]   w_pc_inc;
   logic [PC_WIDTH-1:0]   w_target;

   assign w_type      = r_instr[15:14];
   assign w_sel       = r_instr[13:10];
   assign w_mode      = r_instr[9];
   assign w_cin       = r_instr[8];
   assign w_rd        = r_instr[7:5];
   assign w_rs        = r_instr[4:2];

   assign w_fetching  = (r_state == S_FETCH) || (r_state == S_FETCH_IMM);
   assign w_ack       = w_fetching && imem_ack;
   assign w_in_wb     = (r_state == S_WB);
   assign w_pc_inc    = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
   assign w_target    = imem_rdata[PC_WIDTH-1:0];
   assign w_take_jump = (r_type == 2'b11) &&
                        ((r_sel == OP_JMP) || ((r_sel == OP_JC) && r_carry));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_pc         <= '0;
         r_carry      <= 1'b0;
         r_instr      <= '0;
         r_imm        <= '0;
         r_type       <= '0;
         r_sel        <= '0;
         r_mode       <= 1'b0;
         r_cin        <= 1'b0;
         r_rd         <= '0;
         r_rs         <= '0;
         r_read_addr1 <= '0;
         r_read_addr2 <= '0;
         r_alu_sel    <= '0;
         r_alu_mode   <= 1'b0;
         r_alu_cin    <= 1'b0;
         r_alu_b_imm  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  r_pc    <= '0;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (w_ack) begin
                  r_instr <= imem_rdata[15:2];
                  r_pc    <= w_pc_inc;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_type <= w_type;
               r_sel  <= w_sel;
               r_mode <= w_mode;
               r_cin  <= w_cin;
               r_rd   <= w_rd;
               r_rs   <= w_rs;
               case (w_type)
                  T_ALU_RR: begin
                     // ALU controls are registered here so they are stable for all of EXEC
                     r_read_addr1 <= w_rd;
                     r_read_addr2 <= w_rs;
                     r_alu_sel    <= w_sel;
                     r_alu_mode   <= w_mode;
                     r_alu_cin    <= w_cin;
                     r_alu_b_imm  <= '0;
                     r_state      <= S_EXEC;
                  end
                  T_ALU_RI, T_LDI: r_state <= S_FETCH_IMM;
                  default: begin
                     case (w_sel)
                        OP_HALT:       r_state <= S_HALTED;
                        OP_JMP, OP_JC: r_state <= S_FETCH_IMM;
                        default:       r_state <= S_FETCH;
                     endcase
                  end
               endcase
            end
            S_FETCH_IMM: begin
               if (w_ack) begin
                  r_imm <= imem_rdata;
                  r_pc  <= w_take_jump ? w_target : w_pc_inc;
                  case (r_type)
                     T_ALU_RI: begin
                        r_read_addr1 <= r_rd;
                        r_read_addr2 <= r_rs;
                        r_alu_sel    <= r_sel;
                        r_alu_mode   <= r_mode;
                        r_alu_cin    <= r_cin;
                        r_alu_b_imm  <= imem_rdata;
                        r_state      <= S_EXEC;
                     end
                     T_LDI:   r_state <= S_WB;
                     default: r_state <= S_FETCH;
                  endcase
               end
            end
            S_EXEC: r_state <= S_WB;
            S_WB: begin
               if (r_type != T_LDI) begin
                  r_carry <= alu_cout;
               end
               r_state <= S_FETCH;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem_req         = w_fetching;
   assign imem_addr        = r_pc;
   assign reg_read_addr1   = r_read_addr1;
   assign reg_read_addr2   = r_read_addr2;
   assign alu_sel          = r_alu_sel;
   assign alu_mode         = r_alu_mode;
   assign alu_cin          = r_alu_cin;
   assign alu_b_imm        = r_alu_b_imm;
   assign reg_write_enable = w_in_wb;
   assign reg_write_addr   = w_in_wb ? r_rd : '0;
   assign reg_write_data   = !w_in_wb ? '0 : ((r_type == T_LDI) ? r_imm : alu_result);
   assign busy             = (r_state != S_IDLE) && (r_state != S_HALTED);
   assign halted           = (r_state == S_HALTED);
   assign carry_flag       = r_carry;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - directed bench for cpu_ctrl_seq with an instruction-level reference model
// A small cpu_top stand-in (register file + 74181-style ALU) and an imem responder surround the sequencer.
module tb_cpu_ctrl_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic [2:0]  reg_read_addr1, reg_read_addr2;
   logic [3:0]  alu_sel;
   logic        alu_mode, alu_cin;
   logic [15:0] alu_b_imm;
   logic [15:0] alu_result;
   logic        alu_cout;
   logic        reg_write_enable;
   logic [2:0]  reg_write_addr;
   logic [15:0] reg_write_data;
   logic        busy, halted, carry_flag;

   cpu_ctrl_seq #(.DATA_WIDTH(16), .PC_WIDTH(8), .ADDR_WIDTH(3)) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .reg_read_addr1(reg_read_addr1), .reg_read_addr2(reg_read_addr2),
      .alu_sel(alu_sel), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_b_imm(alu_b_imm),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
      .reg_write_data(reg_write_data),
      .busy(busy), .halted(halted), .carry_flag(carry_flag)
   );

   // Second instance with a 4-bit PC for the wrap case
   logic        reset4 = 1'b1;
   logic        start4 = 1'b0;
   logic        req4;
   logic [3:0]  addr4;
   logic        ack4 = 1'b0;
   logic [15:0] rdata4 = '0;
   logic [2:0]  ra1_4, ra2_4, wa4;
   logic [3:0]  sel4;
   logic        mode4, cin4, we4, busy4, halted4, carry4;
   logic [15:0] bimm4, wd4;

   cpu_ctrl_seq #(.DATA_WIDTH(16), .PC_WIDTH(4), .ADDR_WIDTH(3)) u_dut4 (
      .clk(clk), .reset(reset4), .start(start4),
      .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4), .imem_rdata(rdata4),
      .reg_read_addr1(ra1_4), .reg_read_addr2(ra2_4),
      .alu_sel(sel4), .alu_mode(mode4), .alu_cin(cin4), .alu_b_imm(bimm4),
      .alu_result(16'h0000), .alu_cout(1'b0),
      .reg_write_enable(we4), .reg_write_addr(wa4), .reg_write_data(wd4),
      .busy(busy4), .halted(halted4), .carry_flag(carry4)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [16:0] alu181(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic c);
      logic [16:0] r;
      if (m) begin
         case (s)
            4'h0:    r = {1'b0, ~a};
            4'h6:    r = {1'b0, a ^ b};
            4'hB:    r = {1'b0, a & b};
            4'hE:    r = {1'b0, a | b};
            default: r = {1'b0, a};
         endcase
      end else begin
         case (s)
            4'h0:    r = {1'b0, a} + {16'h0, c};
            4'h6:    r = {1'b0, a} + {1'b0, ~b} + {16'h0, c};
            default: r = {1'b0, a} + {1'b0, b} + {16'h0, c};
         endcase
      end
      return r;
   endfunction

   // cpu_top stand-in: immediate operand replaces R[rs] when non-zero
   logic [15:0] rf [8];
   logic [16:0] alu_out;
   assign alu_out    = alu181(rf[reg_read_addr1], (alu_b_imm != 16'h0) ? alu_b_imm : rf[reg_read_addr2],
                              alu_sel, alu_mode, alu_cin);
   assign alu_result = alu_out[15:0];
   assign alu_cout   = alu_out[16];
   always @(posedge clk) if (reg_write_enable) rf[reg_write_addr] <= reg_write_data;

   logic [59:0] w_all_out;
   assign w_all_out = {imem_req, imem_addr, reg_read_addr1, reg_read_addr2, alu_sel, alu_mode,
                       alu_cin, alu_b_imm, reg_write_enable, reg_write_addr, reg_write_data,
                       busy, halted, carry_flag};

   logic [15:0] mem [256];
   int          delay = 0;
   int          wcnt = 0;
   bit          chk_en = 0, mon_we = 0, we_seen = 0;
   bit          prev_req = 0, prev_ack = 0, prev_we = 0;
   logic [7:0]  prev_addr = '0;
   int          busy_cnt = 0;
   int          exp_fetch [$];
   logic [18:0] exp_wr [$];
   int          exp_final_pc = 0;
   bit          m_carry = 0;
   int          obs_fetch [$];
   logic [18:0] obs_wr [$];
   int          obs_wcyc [$];

   always @(negedge clk) begin
      if (imem_req) begin
         if (wcnt >= delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            wcnt       = 0;
         end else begin
            imem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         imem_ack = 1'b0;
         wcnt     = 0;
      end
      #1;
      if (mon_we && reg_write_enable) we_seen = 1;
      if (chk_en) begin
         if (busy) busy_cnt++;
         if (prev_req && !prev_ack) check("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
         if (imem_req && imem_ack) begin
            obs_fetch.push_back(int'(imem_addr));
            if (exp_fetch.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL extra_fetch: got fetch of 0x%0h, expected none", imem_addr);
            end else check("fetch_addr", imem_addr, exp_fetch.pop_front());
         end
         if (reg_write_enable) begin
            obs_wr.push_back({reg_write_addr, reg_write_data});
            obs_wcyc.push_back(busy_cnt);
            check("wb_single", prev_we, 0);
            if (exp_wr.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL extra_write: got r%0d=0x%0h, expected none", reg_write_addr, reg_write_data);
            end else check("wb_data", {reg_write_addr, reg_write_data}, exp_wr.pop_front());
         end
         prev_req  = imem_req;
         prev_ack  = imem_ack;
         prev_addr = imem_addr;
         prev_we   = reg_write_enable;
      end
   end

   bit chk4 = 0;
   int exp4 = 0;
   int fetch4 = 0;
   always @(negedge clk) begin
      ack4   = req4;
      rdata4 = 16'hC000;
      #1;
      if (chk4 && req4 && ack4) begin
         check("wrap_addr", addr4, exp4);
         exp4 = (exp4 + 1) % 16;
         fetch4++;
      end
   end

   // Instruction-level interpreter: what the program must do, independent of cycle timing
   task automatic build_expect();
      int          pc;
      logic [15:0] r [8];
      logic [15:0] w, imm;
      logic [16:0] ar;
      bit          done;
      exp_fetch.delete();
      exp_wr.delete();
      for (int i = 0; i < 8; i++) r[i] = rf[i];
      pc = 0;
      done = 0;
      for (int n = 0; n < 300 && !done; n++) begin
         w = mem[pc];
         exp_fetch.push_back(pc);
         pc = (pc + 1) % 256;
         imm = 16'h0;
         if (w[15:14] != 2'b00 && !(w[15:14] == 2'b11 && w[13:10] != 4'h2 && w[13:10] != 4'h3)) begin
            imm = mem[pc];
            exp_fetch.push_back(pc);
            pc = (pc + 1) % 256;
         end
         case (w[15:14])
            2'b00, 2'b01: begin
               ar = alu181(r[w[7:5]], (w[15:14] == 2'b00) ? r[w[4:2]] : imm, w[13:10], w[9], w[8]);
               r[w[7:5]] = ar[15:0];
               m_carry = ar[16];
               exp_wr.push_back({w[7:5], ar[15:0]});
            end
            2'b10: begin
               r[w[7:5]] = imm;
               exp_wr.push_back({w[7:5], imm});
            end
            default: begin
               case (w[13:10])
                  4'h1: done = 1;
                  4'h2: pc = int'(imm[7:0]);
                  4'h3: if (m_carry) pc = int'(imm[7:0]);
                  default: ;
               endcase
            end
         endcase
      end
      exp_final_pc = pc;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hC400;
   endtask

   task automatic load_prog1();
      clear_mem();
      mem[0] = 16'h8040; mem[1] = 16'h1234;
      mem[2] = 16'h8060; mem[3] = 16'h5678;
      mem[4] = 16'h244C; mem[5] = 16'hC400;
   endtask

   task automatic run_prog(input string nm, input int d, input int budget);
      int cyc;
      delay = d;
      build_expect();
      obs_fetch.delete(); obs_wr.delete(); obs_wcyc.delete();
      busy_cnt = 0; prev_req = 0; prev_ack = 0; prev_we = 0;
      chk_en = 1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!halted && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      #2;
      check({nm, "_halted"}, halted, 1);
      chk_en = 0;
      check({nm, "_busy"}, busy, 0);
      check({nm, "_fetch_left"}, exp_fetch.size(), 0);
      check({nm, "_write_left"}, exp_wr.size(), 0);
      check({nm, "_final_pc"}, imem_addr, exp_final_pc);
   endtask

   logic [18:0] lit_wr [3];
   int          lit_cyc0 [3];
   int          lit_cyc3 [3];
   int          lit_jc [9];
   int          cyc;
   bit          found;

   initial begin
      lit_wr[0] = {3'd2, 16'h1234}; lit_wr[1] = {3'd3, 16'h5678}; lit_wr[2] = {3'd2, 16'h68AC};
      lit_cyc0[0] = 4;  lit_cyc0[1] = 8;  lit_cyc0[2] = 12;
      lit_cyc3[0] = 10; lit_cyc3[1] = 20; lit_cyc3[2] = 27;
      for (int i = 0; i < 8; i++) lit_jc[i] = i;
      lit_jc[8] = 8'h30;
      clear_mem();

      repeat (2) @(negedge clk);
      #2;
      check("reset_outs", w_all_out, 0);
      check("reset4_outs", {req4, addr4, busy4, halted4, we4, carry4}, 0);
      reset = 1'b0; reset4 = 1'b0; m_carry = 0;

      // LDI r2 / LDI r3 / ADD r2,r3 / HALT, zero-wait then 3-cycle-wait memory
      load_prog1();
      run_prog("p1w0", 0, 200);
      check("p1w0_nwr", obs_wr.size(), 3);
      for (int i = 0; i < 3; i++) if (obs_wr.size() > i) begin
         check("p1w0_wr_lit", obs_wr[i], lit_wr[i]);
         check("p1w0_wr_cyc", obs_wcyc[i], lit_cyc0[i]);
      end
      check("p1w0_busy_cycles", busy_cnt, 14);
      check("p1w0_pc6", imem_addr, 6);

      run_prog("p1w3", 3, 300);
      check("p1w3_nwr", obs_wr.size(), 3);
      for (int i = 0; i < 3; i++) if (obs_wr.size() > i) begin
         check("p1w3_wr_lit", obs_wr[i], lit_wr[i]);
         check("p1w3_wr_cyc", obs_wcyc[i], lit_cyc3[i]);
      end
      check("p1w3_busy_cycles", busy_cnt, 32);

      // JC untaken (carry 0), RI 0xFFFF+1 sets carry, JC taken
      clear_mem();
      mem[0] = 16'h8000; mem[1] = 16'hFFFF;
      mem[2] = 16'hCC00; mem[3] = 16'h0020;
      mem[4] = 16'h6400; mem[5] = 16'h0001;
      mem[6] = 16'hCC00; mem[7] = 16'h0030;
      mem[8] = 16'h80E0; mem[9] = 16'hDEAD;
      run_prog("jc", 1, 300);
      check("jc_nfetch", obs_fetch.size(), 9);
      for (int i = 0; i < 9; i++) if (obs_fetch.size() > i) check("jc_fetch_lit", obs_fetch[i], lit_jc[i]);
      check("jc_nwr", obs_wr.size(), 2);
      if (obs_wr.size() > 1) check("jc_ri_wr", obs_wr[1], {3'd0, 16'h0000});
      check("jc_carry", carry_flag, 1);
      check("jc_pc", imem_addr, 8'h31);

      // Reset while waiting on an immediate fetch
      clear_mem();
      mem[0] = 16'h8020; mem[1] = 16'hABCD;
      delay = 3; we_seen = 0; mon_we = 1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0; found = 0;
      while (!found && cyc < 50) begin
         @(negedge clk); #2;
         if (imem_req && imem_addr == 8'd1) found = 1;
         cyc++;
      end
      check("rst_reach_fetch_imm", found, 1);
      reset = 1'b1; m_carry = 0;
      @(negedge clk); #2;
      check("rst_req", imem_req, 0);
      check("rst_outs", w_all_out, 0);
      reset = 1'b0;
      @(negedge clk); #2;
      mon_we = 0;
      check("rst_no_write", we_seen, 0);
      check("rst_idle", {busy, halted}, 0);

      // JMP at address 0 straight after the reset: word 2 must never be fetched
      clear_mem();
      mem[0] = 16'hC800; mem[1] = 16'h0010;
      mem[2] = 16'h80E0; mem[3] = 16'hBEEF;
      run_prog("jmp", 0, 100);
      check("jmp_nfetch", obs_fetch.size(), 3);
      if (obs_fetch.size() > 2) check("jmp_target_fetch", obs_fetch[2], 8'h10);
      check("jmp_pc", imem_addr, 8'h11);

      // 4-bit PC wrap with NOPs everywhere and start pulses ignored while busy
      exp4 = 0; fetch4 = 0; chk4 = 1;
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      cyc = 0;
      while (fetch4 < 40 && cyc < 200) begin
         @(negedge clk);
         start4 = (cyc % 7 == 3);
         cyc++;
      end
      start4 = 1'b0;
      #2;
      check("wrap_progress", fetch4 >= 40, 1);
      check("wrap_busy", busy4, 1);
      chk4 = 0;
      reset4 = 1'b1;
      @(negedge clk); #2;
      check("wrap_reset", {req4, addr4, busy4}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1);
   end

endmodule
